// File: rtl/sha3_absorb_pad.sv
// SHA3 absorb/pad front end: byte-stream absorb into the Keccak state, pad10*1 with a
// domain byte, start/done handoff to the permutation core, digest hold until acknowledged.
// Compile-time option: SHA3_KECCAK_LEGACY_EN selects the original Keccak domain byte (0x01).
module sha3_absorb_pad #(
  parameter int RATE_BYTES  = 136,
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   in_empty,
  output logic                   in_ready,
  output logic                   perm_start,
  output logic [1599:0]          state_out,
  input  logic [1599:0]          state_in,
  input  logic                   perm_done,
  output logic [DIGEST_BITS-1:0] digest,
  output logic                   digest_valid,
  input  logic                   digest_ack
);

`ifdef SHA3_KECCAK_LEGACY_EN
  localparam logic [7:0] DOMAIN = 8'h01;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  localparam logic [7:0] K_LAST   = 8'(RATE_BYTES - 1);
  localparam int         LAST_BIT = 8 * (RATE_BYTES - 1);

  // Handshake: a byte transfers on the rising edge where in_valid && in_ready;
  // the source holds in_byte/in_last/in_empty stable until then.
  typedef enum logic [2:0] {ABSORB, PAD, PERM, WAIT, OUT} state_t;

  state_t          state_q, state_d;
  logic [1599:0]   s_q;
  logic [7:0]      k_q;
  logic            final_q;
  logic            pad_pending_q;
  logic [10:0]     bit_idx;
  logic [1599:0]   byte_vec;
  logic [1599:0]   pad_vec;
  logic            accept;
  logic            is_empty;
  logic            fills;

  assign bit_idx  = {k_q, 3'b000};
  assign in_ready = (state_q == ABSORB) && !RST;
  assign accept   = in_valid && in_ready;
  assign is_empty = in_last && in_empty;
  assign fills    = (k_q == K_LAST);

  assign perm_start   = (state_q == PERM);
  assign state_out    = s_q;
  assign digest_valid = (state_q == OUT);
  assign digest       = digest_valid ? s_q[DIGEST_BITS-1:0] : '0;

  // Byte and padding contributions as full-width masks; the two pad bytes may coincide.
  always_comb begin
    byte_vec = '0;
    pad_vec  = '0;
    byte_vec[bit_idx +: 8] = in_byte;
    pad_vec[bit_idx +: 8]  = DOMAIN;
    pad_vec[LAST_BIT +: 8] = pad_vec[LAST_BIT +: 8] ^ 8'h80;
  end

  always_ff @(posedge clk) begin
    if (RST) state_q <= ABSORB;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ABSORB: begin
        if (accept) begin
          if (in_last) state_d = (!is_empty && fills) ? PERM : PAD;
          else if (fills) state_d = PERM;
        end
      end
      PAD:  state_d = PERM;
      PERM: state_d = WAIT;
      WAIT: begin
        if (perm_done) begin
          if (final_q)            state_d = OUT;
          else if (pad_pending_q) state_d = PAD;
          else                    state_d = ABSORB;
        end
      end
      OUT:     if (digest_ack) state_d = ABSORB;
      default: state_d = ABSORB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s_q           <= '0;
      k_q           <= '0;
      final_q       <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      case (state_q)
        ABSORB: begin
          if (accept) begin
            final_q <= 1'b0;
            if (!is_empty) begin
              s_q <= s_q ^ byte_vec;
              k_q <= k_q + 8'd1;
            end
            // Last byte exactly fills the block: padding goes into a block of its own.
            if (in_last && !is_empty && fills) pad_pending_q <= 1'b1;
          end
        end
        PAD: begin
          s_q           <= s_q ^ pad_vec;
          final_q       <= 1'b1;
          pad_pending_q <= 1'b0;
        end
        WAIT: begin
          if (perm_done) begin
            s_q <= state_in;
            k_q <= '0;
          end
        end
        OUT: begin
          if (digest_ack) begin
            s_q     <= '0;
            final_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Bench for sha3_absorb_pad: message-level padding model, stand-in permutation,
// per-cycle compare of state_out / digest, plus literal lane checks.
module tb_sha3_absorb_pad;
  localparam int R = 136;
`ifdef SHA3_KECCAK_LEGACY_EN
  localparam logic [7:0] DOM = 8'h01;
`else
  localparam logic [7:0] DOM = 8'h06;
`endif

  logic          clk;
  logic          RST;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_last;
  logic          in_empty;
  logic          in_ready;
  logic          perm_start;
  logic [1599:0] state_out;
  logic [1599:0] state_in;
  logic          perm_done;
  logic [255:0]  digest;
  logic          digest_valid;
  logic          digest_ack;

  sha3_absorb_pad #(.RATE_BYTES(R), .DIGEST_BITS(256)) dut (
    .clk(clk), .RST(RST), .in_byte(in_byte), .in_valid(in_valid), .in_last(in_last),
    .in_empty(in_empty), .in_ready(in_ready), .perm_start(perm_start), .state_out(state_out),
    .state_in(state_in), .perm_done(perm_done), .digest(digest), .digest_valid(digest_valid),
    .digest_ack(digest_ack)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [7:0]    msg [0:511];
  logic [1599:0] exp_q [$];
  logic [1599:0] resp_q [$];
  logic [255:0]  exp_digest;
  logic [1599:0] last_state;
  logic [1599:0] cmp_e;
  logic [1599:0] resp_v;
  int            perm_seen = 0;
  int            perm_delay = 2;
  bit            inflight = 1'b0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [1599:0] act, input logic [1599:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      for (int l = 0; l < 25; l++) begin
        if (act[64*l +: 64] !== exp[64*l +: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, l, act[64*l +: 64], exp[64*l +: 64]);
          break;
        end
      end
    end
  endtask

  // stand-in permutation: any fixed bijection serves to track the state through blocks
  function automatic logic [1599:0] perm_model(input logic [1599:0] x);
    return {x[1598:0], x[1599]} ^ {25{64'h0123456789ABCDEF}};
  endfunction

  // pad10*1 over the byte message, absorb block by block, queue expected states
  task automatic model_msg(input int len);
    logic [7:0]    pb [0:1023];
    logic [1599:0] s;
    int            p;
    p = (len / R + 1) * R;
    for (int j = 0; j < p; j++) pb[j] = (j < len) ? msg[j] : 8'h00;
    pb[len]   = pb[len] ^ DOM;
    pb[p-1]   = pb[p-1] ^ 8'h80;
    s = '0;
    for (int b = 0; b < p / R; b++) begin
      for (int j = 0; j < R; j++) s[8*j +: 8] = s[8*j +: 8] ^ pb[b*R + j];
      exp_q.push_back(s);
      s = perm_model(s);
    end
    exp_digest = s[255:0];
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (perm_start) begin
      perm_seen++;
      last_state = state_out;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_perm_start: got 1 expected 0");
      end else begin
        cmp_e = exp_q.pop_front();
        check_wide("state_out", state_out, cmp_e);
        resp_q.push_back(perm_model(cmp_e));
        inflight = 1'b1;
      end
    end else if (inflight) begin
      check64("in_ready_busy", {63'b0, in_ready}, 64'd0);
    end
    if (digest_valid) check_wide("digest", {1344'b0, digest}, {1344'b0, exp_digest});
  end

  // permutation core stand-in
  initial begin
    perm_done = 1'b0;
    state_in  = '0;
    forever begin
      @(negedge clk);
      if (resp_q.size() > 0) begin
        resp_v = resp_q.pop_front();
        repeat (perm_delay) @(negedge clk);
        state_in  = resp_v;
        perm_done = 1'b1;
        inflight  = 1'b0;
        @(negedge clk);
        perm_done = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit last, input bit empty);
    int budget = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    in_empty = empty;
    while (!in_ready) begin
      @(negedge clk);
      budget++;
      if (budget > 500) begin
        check64("accept_timeout", 64'd0, 64'd1);
        return;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_msg(input int len);
    model_msg(len);
    if (len == 0) send_byte(8'h00, 1'b1, 1'b1);
    else for (int i = 0; i < len; i++) send_byte(msg[i], i == len - 1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic wait_perm(input int target);
    int budget = 0;
    while (perm_seen < target && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check64("perm_start_count", 64'(perm_seen), 64'(target));
  endtask

  task automatic finish_msg();
    int budget = 0;
    while (!digest_valid && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check64("digest_valid_seen", {63'b0, digest_valid}, 64'd1);
    repeat (3) @(negedge clk);
    check64("digest_valid_held", {63'b0, digest_valid}, 64'd1);
    digest_ack = 1'b1;
    @(negedge clk);
    digest_ack = 1'b0;
    check64("digest_valid_cleared", {63'b0, digest_valid}, 64'd0);
    check64("in_ready_after_ack", {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    int base;
    RST = 1'b1; in_byte = 8'h00; in_valid = 1'b0; in_last = 1'b0; in_empty = 1'b0;
    digest_ack = 1'b0;
    repeat (3) @(negedge clk);
    check64("rst_in_ready", {63'b0, in_ready}, 64'd0);
    check64("rst_perm_start", {63'b0, perm_start}, 64'd0);
    check64("rst_digest_valid", {63'b0, digest_valid}, 64'd0);
    check64("rst_digest_lo", digest[63:0], 64'd0);
    check_wide("rst_state_out", state_out, '0);
    RST = 1'b0;
    @(negedge clk);
    check64("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

    // empty message
    base = perm_seen;
    send_msg(0);
    wait_perm(base + 1);
    check64("empty_lane00", last_state[63:0], {56'b0, DOM});
    check64("empty_lane13", last_state[64*16 +: 64], 64'h8000000000000000);
    check64("empty_lane01", last_state[127:64], 64'd0);
    finish_msg();

    // single byte "a", with last-byte to perm_start latency
    msg[0] = 8'h61;
    base = perm_seen;
    send_msg(1);
    check64("pad_cycle_no_start", {63'b0, perm_start}, 64'd0);
    @(negedge clk);
    check64("perm_start_at_2", {63'b0, perm_start}, 64'd1);
    wait_perm(base + 1);
    check64("a_lane00", last_state[63:0], {48'b0, DOM, 8'h61});
    check64("a_lane13", last_state[64*16 +: 64], 64'h8000000000000000);
    finish_msg();

    // 135 zero bytes: both pad bits land in the last rate byte
    for (int i = 0; i < 135; i++) msg[i] = 8'h00;
    base = perm_seen;
    send_msg(135);
    wait_perm(base + 1);
    check64("z135_lane13", last_state[64*16 +: 64], {DOM | 8'h80, 56'b0});
    finish_msg();
    check64("z135_perm_count", 64'(perm_seen), 64'(base + 1));

    // 136 0xFF bytes: full block, then a pure padding block
    for (int i = 0; i < 136; i++) msg[i] = 8'hFF;
    base = perm_seen;
    send_msg(136);
    wait_perm(base + 1);
    check64("ff_lane00", last_state[63:0], 64'hFFFFFFFFFFFFFFFF);
    check64("ff_lane13", last_state[64*16 +: 64], 64'hFFFFFFFFFFFFFFFF);
    check64("ff_lane23", last_state[64*17 +: 64], 64'd0);
    wait_perm(base + 2);
    finish_msg();

    // long permutation latency with in_valid held through WAIT
    perm_delay = 20;
    for (int i = 0; i < 140; i++) msg[i] = 8'(i * 7 + 3);
    base = perm_seen;
    send_msg(140);
    wait_perm(base + 2);
    finish_msg();

    // reset while waiting on the permutation, then a stray perm_done
    perm_delay = 4;
    for (int i = 0; i < 3; i++) msg[i] = 8'(8'hA0 + i);
    base = perm_seen;
    send_msg(3);
    wait_perm(base + 1);
    @(negedge clk);
    RST = 1'b1;
    inflight = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    repeat (10) @(negedge clk);
    check_wide("post_rst_state_out", state_out, '0);
    check64("post_rst_digest_valid", {63'b0, digest_valid}, 64'd0);
    check64("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    check64("post_rst_no_perm", 64'(perm_seen), 64'(base + 1));
    perm_delay = 2;
    msg[0] = 8'h61;
    base = perm_seen;
    send_msg(1);
    wait_perm(base + 1);
    check64("post_rst_a_lane00", last_state[63:0], {48'b0, DOM, 8'h61});
    finish_msg();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    n_checks++;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/sha3_absorb_pad.md
Name: sha3_absorb_pad

Overview:
- Upstream feeder for the Keccak-f[1600] round datapath (theta/rho/pi/chi/iota).
- Accepts a message as a byte stream with a valid/ready handshake and applies SHA3 pad10*1 padding with a domain byte.
- XORs each rate block into the 1600-bit state, then hands the state to the permutation core through a start/done handshake.
- After the final permutation, presents the 256-bit digest until it is acknowledged.

Parameters:
- RATE_BYTES, 136, rate in bytes (1088 bits, SHA3-256); legal range 8..192, multiple of 8.
- DIGEST_BITS, 256, digest width taken from lanes 0.. upward.

Ports:
- clk  in  1  system clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_byte  in  8  message byte.
- in_valid  in  1  in_byte valid.
- in_last  in  1  qualifies the final byte of the message.
- in_empty  in  1  with in_valid & in_last: zero-length message, in_byte ignored.
- in_ready  out  1  block accepts a byte this cycle.
- perm_start  out  1  one-cycle pulse; state_out valid.
- state_out  out  1600  state to permutation; lane (x,y) at bits [64*(x+5y)+:64].
- state_in  in  1600  permuted state, same packing.
- perm_done  in  1  one-cycle pulse; state_in valid.
- digest  out  DIGEST_BITS  lanes (0,0),(1,0),... little-endian concatenation, lane0 at LSBs.
- digest_valid  out  1  digest held stable.
- digest_ack  in  1  consumer took digest.

Behaviour:
- Reset values: in_ready=0, perm_start=0, state_out=0, digest=0, digest_valid=0, internal state S=0, byte counter k=0, FSM=ABSORB.
- FSM states: ABSORB, PAD, PERM, WAIT, OUT.
- ABSORB:
  - in_ready=1 the cycle after reset deassertion and whenever in ABSORB.
  - Byte accepted on in_valid & in_ready.
  - Byte k is XORed into S: lane index i=k/8, x=i%5, y=i/5, bit offset 8*(k%8).
  - k increments on each accepted byte.
- Transitions out of ABSORB:
  - Accepted byte makes k==RATE_BYTES and in_last=0 → PERM, final flag=0.
  - Accepted byte with in_last=1 (or in_empty) → PAD.
  - in_last on the byte that fills the block: go to PERM with pad_pending=1, so the next block is pure padding.
- PAD (one cycle):
  - S byte k ^= DOMAIN and S byte RATE_BYTES-1 ^= 0x80.
  - If k==RATE_BYTES-1, the single byte gets DOMAIN^0x80 (0x86).
  - Set final=1 → PERM.
- PERM: state_out=S, perm_start=1 for exactly one cycle → WAIT. in_ready=0.
- WAIT:
  - in_ready=0.
  - On perm_done: S<=state_in, k<=0.
  - Then: final → OUT; pad_pending → PAD (k=0, clear pad_pending); else → ABSORB.
- OUT:
  - digest=S[DIGEST_BITS-1:0], digest_valid=1 held.
  - On digest_ack: S<=0, digest_valid=0 next cycle → ABSORB.
- perm_done outside WAIT is ignored. in_valid outside ABSORB is not accepted; the source must hold data.
- RST mid-operation, any state: return to reset values next edge. A perm_done arriving after reset is ignored.
- Latency: last byte to perm_start is 2 cycles (PAD, PERM). perm_done to digest_valid is 1 cycle.

Optional Feature:
- SHA3_KECCAK_LEGACY_EN defined: DOMAIN=8'h01 (original Keccak-256, as used by Ethereum PoW).
- Undefined: DOMAIN=8'h06 (FIPS-202 SHA3-256).
- No other behaviour changes.

Test Plan:
- Empty message (in_valid,in_last,in_empty) → at perm_start: lane(0,0)=0x06, lane(1,3)=0x8000000000000000, all other lanes 0; with SHA3_KECCAK_LEGACY_EN, lane(0,0)=0x01.
- Single byte 0x61 "a" → lane(0,0)=0x0661, lane(1,3)=0x8000000000000000; bench model permutation returns a known value; digest equals its low 256 bits.
- 135 bytes of 0x00 → one perm_start; lane(1,3)=0x8600000000000000.
- 136 bytes of 0xFF → two perm_starts:
  - First state_out has rate all 0xFF.
  - Second state_out = permuted state XOR padding block (0x06 at byte 0, 0x80 at byte 135).
  - in_ready=0 between the two.
- in_valid held during WAIT for 20 cycles with perm_done delayed → no byte lost or duplicated; k resumes at 0.
- RST asserted in WAIT, then a stray perm_done → state_out=0, digest_valid=0, FSM accepts a new message normally.
